uart_rx_word: RTL and testbench

UART_RX_WORD -- requirements
Module: uart_rx_word

---
 rtl/uart_rx_word.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_word.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word.sv
// UART receiver that pairs two characters (low then high) into one word.
// Optional `UART_RX_TIMEOUT_EN drops a stale pending low character after TIMEOUT_BITS idle bit times.
module uart_rx_word #(
  parameter int UART_DATA_SIZE = 8,
  parameter int CLKS_PER_BIT   = 868,
  parameter int TIMEOUT_BITS   = 20
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_rx,
  output logic [UART_DATA_SIZE-1:0] o_data_l,
  output logic [UART_DATA_SIZE-1:0] o_data_h,
  output logic                      o_valid,
  output logic                      o_frame_err,
  output logic                      o_busy
);

  // state | meaning
  // IDLE  | waiting for a falling edge on the synchronized line
  // START | timing to mid start bit, rejecting glitches
  // DATA  | sampling data bits LSB first at mid bit
  // STOP  | sampling the stop bit, then accept or flag framing error
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (UART_DATA_SIZE > 1) ? $clog2(UART_DATA_SIZE) : 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(UART_DATA_SIZE - 1);

  if (CLKS_PER_BIT < 8 || TIMEOUT_BITS < 1) begin : g_bad_param
    $error("uart_rx_word: CLKS_PER_BIT must be >= 8 and TIMEOUT_BITS >= 1");
  end

  state_t                    state, state_nx;
  logic                      rx_s1, rx_s2, vld_s1, vld_s2, rx_prev;
  logic                      start_edge;
  logic [CW-1:0]             cnt;
  logic                      tc;
  logic [BW-1:0]             bit_cnt;
  logic [UART_DATA_SIZE-1:0] shreg;
  logic [UART_DATA_SIZE-1:0] low_pend;
  logic                      pending;
  logic                      load_half, load_full, data_sample, stop_sample;

  // rx_prev only becomes high from a genuinely sampled high line, so a line
  // already low when reset releases never looks like a start edge.
  assign start_edge = rx_prev & ~rx_s2;
  assign tc         = (cnt == '0);
  assign o_busy     = (state != IDLE) | pending;

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    load_half   = 1'b0;
    load_full   = 1'b0;
    data_sample = 1'b0;
    stop_sample = 1'b0;
    case (state)
      IDLE: if (start_edge) begin
        state_nx  = START;
        load_half = 1'b1;
      end
      START: if (tc) begin
        if (!rx_s2) begin
          state_nx  = DATA;
          load_full = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      DATA: if (tc) begin
        data_sample = 1'b1;
        load_full   = 1'b1;
        if (bit_cnt == LAST_BIT) state_nx = STOP;
      end
      STOP: if (tc) begin
        stop_sample = 1'b1;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_BITS * CLKS_PER_BIT);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  logic [TW-1:0] tmo_cnt;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      vld_s1      <= 1'b0;
      vld_s2      <= 1'b0;
      rx_prev     <= 1'b0;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      low_pend    <= '0;
      pending     <= 1'b0;
      o_data_l    <= '0;
      o_data_h    <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      rx_s1       <= i_rx;
      rx_s2       <= rx_s1;
      vld_s1      <= 1'b1;
      vld_s2      <= vld_s1;
      rx_prev     <= vld_s2 & rx_s2;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;

      if (load_half)      cnt <= HALF_LOAD;
      else if (load_full) cnt <= FULL_LOAD;
      else if (!tc)       cnt <= cnt - 1'b1;

      if (load_half) bit_cnt <= '0;
      if (data_sample) begin
        shreg   <= UART_DATA_SIZE'({rx_s2, shreg} >> 1);
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (stop_sample) begin
        if (!rx_s2) begin
          pending     <= 1'b0;
          o_frame_err <= 1'b1;
        end else if (pending) begin
          o_data_l <= low_pend;
          o_data_h <= shreg;
          o_valid  <= 1'b1;
          pending  <= 1'b0;
        end else begin
          low_pend <= shreg;
          pending  <= 1'b1;
        end
      end

`ifdef UART_RX_TIMEOUT_EN
      // Only idle time counts toward expiry of a pending low character.
      if (stop_sample && rx_s2 && !pending) begin
        tmo_cnt <= TMO_LOAD;
      end else if (state == IDLE && pending && !start_edge) begin
        if (tmo_cnt == '0) pending <= 1'b0;
        else               tmo_cnt <= tmo_cnt - 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_word.sv
// Self-checking bench for uart_rx_word: scenario tasks plus randomized character
// streams checked against a word-pairing reference model.
module tb_uart_rx_word;
  localparam int CPB      = 16;
  localparam int TMO_BITS = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_l, data_h;
  logic       valid, frame_err, busy;

  int checks = 0;
  int errors = 0;

  uart_rx_word #(.UART_DATA_SIZE(8), .CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TMO_BITS)) dut (
    .i_clock(clk), .i_reset(rst), .i_rx(rx),
    .o_data_l(data_l), .o_data_h(data_h),
    .o_valid(valid), .o_frame_err(frame_err), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor: pulses, observed words, double pulses, output changes without o_valid.
  int          n_valid = 0, n_ferr = 0, n_dbl = 0, n_hold = 0;
  logic [15:0] obs_q[$];
  logic [15:0] prev_data = 16'h0;
  logic        prev_valid = 1'b0, prev_ferr = 1'b0, rst_d = 1'b1;

  always @(negedge clk) begin
    if (valid) begin
      n_valid <= n_valid + 1;
      obs_q.push_back({data_l, data_h});
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if ((valid && prev_valid) || (frame_err && prev_ferr)) n_dbl <= n_dbl + 1;
    if (!valid && !rst && !rst_d && ({data_l, data_h} != prev_data)) n_hold <= n_hold + 1;
    prev_data  <= {data_l, data_h};
    prev_valid <= valid;
    prev_ferr  <= frame_err;
    rst_d      <= rst;
  end

  // Reference model: characters pair up low/high; a bad stop bit drops everything.
  logic        mdl_pending = 1'b0;
  logic [7:0]  mdl_low = 8'h0;
  logic [15:0] exp_last = 16'h0;
  int          exp_valid = 0, exp_ferr = 0, last_gap = 0;
  logic [15:0] exp_q[$];

  task automatic model_reset();
    mdl_pending = 1'b0;
    exp_last    = 16'h0;
    last_gap    = 0;
  endtask

  task automatic model_char(input logic [7:0] c, input logic stop_ok);
`ifdef UART_RX_TIMEOUT_EN
    if (mdl_pending && last_gap >= TMO_BITS) mdl_pending = 1'b0;
`endif
    if (!stop_ok) begin
      mdl_pending = 1'b0;
      exp_ferr++;
    end else if (mdl_pending) begin
      exp_last = {mdl_low, c};
      exp_q.push_back(exp_last);
      exp_valid++;
      mdl_pending = 1'b0;
    end else begin
      mdl_low     = c;
      mdl_pending = 1'b1;
    end
  endtask

  task automatic drive_bits(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_char(input logic [7:0] c, input logic stop_ok, input int gap_bits);
    model_char(c, stop_ok);
    drive_bits(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bits(c[i], CPB);
    drive_bits(stop_ok, CPB);
    if (gap_bits > 0) drive_bits(1'b1, gap_bits * CPB);
    rx = 1'b1;
    last_gap = gap_bits;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: valid=%b frame_err=%b, expected 0 0", valid, frame_err);
    end
    checks++;
    if ({data_l, data_h} !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: got %h, expected 0000", {data_l, data_h});
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b, expected 0", busy);
    end
    rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_word();
    send_char(8'h34, 1'b1, 1);
    send_char(8'h12, 1'b1, 1);
    repeat (CPB) @(negedge clk);
    checks++;
    if (n_valid !== exp_valid) begin
      errors++;
      $display("FAIL word_count: got %0d valid pulses, expected %0d", n_valid, exp_valid);
    end
    checks++;
    if ({data_l, data_h} !== exp_last) begin
      errors++;
      $display("FAIL word_data: got %h, expected %h", {data_l, data_h}, exp_last);
    end
    checks++;
    if (n_ferr !== exp_ferr || busy !== 1'b0) begin
      errors++;
      $display("FAIL word_idle: frame_err count %0d busy %b, expected %0d 0", n_ferr, busy, exp_ferr);
    end
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = n_valid;
    f0 = n_ferr;
    drive_bits(1'b0, 4);
    drive_bits(1'b1, 8);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy: got %b 12 cycles after glitch, expected 0", busy);
    end
    repeat (2 * CPB) @(negedge clk);
    checks++;
    if (n_valid !== v0 || n_ferr !== f0) begin
      errors++;
      $display("FAIL glitch_pulses: valid %0d ferr %0d, expected %0d %0d", n_valid, n_ferr, v0, f0);
    end
  endtask

  task automatic test_frame_err();
    send_char(8'hAA, 1'b0, 2);
    checks++;
    if (n_ferr !== exp_ferr || n_valid !== exp_valid) begin
      errors++;
      $display("FAIL ferr_pulse: ferr %0d valid %0d, expected %0d %0d", n_ferr, n_valid, exp_ferr, exp_valid);
    end
    send_char(8'h01, 1'b1, 1);
    send_char(8'h02, 1'b1, 1);
    repeat (CPB) @(negedge clk);
    checks++;
    if ({data_l, data_h} !== exp_last || n_valid !== exp_valid) begin
      errors++;
      $display("FAIL ferr_recover: got %h (%0d words), expected %h (%0d)", {data_l, data_h}, n_valid, exp_last, exp_valid);
    end
  endtask

  task automatic test_reset_mid();
    int v0, f0;
    send_char(8'h34, 1'b1, 1);
    send_char(8'h12, 1'b1, 1);
    send_char(8'h99, 1'b1, 1);
    v0 = n_valid + 0;
    f0 = n_ferr;
    drive_bits(1'b0, CPB);
    for (int i = 0; i < 3; i++) drive_bits(1'b1, CPB);
    drive_bits(1'b0, CPB / 2);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({data_l, data_h} !== 16'h0 || busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: data %h busy %b valid %b, expected 0000 0 0", {data_l, data_h}, busy, valid);
    end
    rst = 1'b0;
    rx  = 1'b1;
    model_reset();
    repeat (2 * CPB) @(negedge clk);
    checks++;
    if (n_valid !== v0 || n_ferr !== f0) begin
      errors++;
      $display("FAIL reset_mid_pulses: valid %0d ferr %0d, expected %0d %0d", n_valid, n_ferr, v0, f0);
    end
    send_char(8'h5A, 1'b1, 1);
    send_char(8'hA5, 1'b1, 1);
    repeat (CPB) @(negedge clk);
    checks++;
    if ({data_l, data_h} !== exp_last) begin
      errors++;
      $display("FAIL reset_mid_word: got %h, expected %h", {data_l, data_h}, exp_last);
    end
  endtask

  task automatic test_reset_start();
    int v0, f0;
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    v0 = n_valid;
    f0 = n_ferr;
    drive_bits(1'b0, 5 * CPB);
    drive_bits(1'b1, 10 * CPB);
    checks++;
    if (busy !== 1'b0 || n_valid !== v0 || n_ferr !== f0) begin
      errors++;
      $display("FAIL reset_start: busy %b valid %0d ferr %0d, expected 0 %0d %0d", busy, n_valid, n_ferr, v0, f0);
    end
    send_char(8'h3C, 1'b1, 1);
    send_char(8'hC3, 1'b1, 1);
    repeat (CPB) @(negedge clk);
    checks++;
    if ({data_l, data_h} !== exp_last) begin
      errors++;
      $display("FAIL reset_start_word: got %h, expected %h", {data_l, data_h}, exp_last);
    end
  endtask

  task automatic test_timeout();
    send_char(8'h55, 1'b1, 25);
    send_char(8'h66, 1'b1, 0);
    send_char(8'h77, 1'b1, 2);
    checks++;
    if ({data_l, data_h} !== exp_last || n_valid !== exp_valid) begin
      errors++;
      $display("FAIL timeout_word: got %h (%0d words), expected %h (%0d)", {data_l, data_h}, n_valid, exp_last, exp_valid);
    end
    checks++;
    if (busy !== mdl_pending) begin
      errors++;
      $display("FAIL timeout_busy: got %b, expected %b", busy, mdl_pending);
    end
    apply_reset();
  endtask

  task automatic test_back_to_back();
    obs_q.delete();
    exp_q.delete();
    send_char(8'h11, 1'b1, 0);
    send_char(8'h22, 1'b1, 0);
    send_char(8'h33, 1'b1, 0);
    send_char(8'h44, 1'b1, 2);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d words, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_word%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (n_dbl !== 0 || n_hold !== 0) begin
      errors++;
      $display("FAIL b2b_pulse_hold: double pulses %0d hold violations %0d, expected 0 0", n_dbl, n_hold);
    end
  endtask

  task automatic test_random();
    logic [7:0] c;
    logic       ok;
    obs_q.delete();
    exp_q.delete();
    for (int k = 0; k < 24; k++) begin
      c  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
      send_char(c, ok, ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2)));
    end
    repeat (CPB) @(negedge clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d words, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_word%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (n_ferr !== exp_ferr || busy !== mdl_pending) begin
      errors++;
      $display("FAIL rand_state: ferr %0d busy %b, expected %0d %b", n_ferr, busy, exp_ferr, mdl_pending);
    end
    checks++;
    if (n_dbl !== 0 || n_hold !== 0) begin
      errors++;
      $display("FAIL rand_pulse_hold: double pulses %0d hold violations %0d, expected 0 0", n_dbl, n_hold);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_reset_start();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
